dac_spi_arb: RTL

- Shares the single 24-bit LTC2612 DAC SPI master between two requesters:
  - port 0: the register-interface write path;
  - port 1: an autonomous DAC update/scan engine.
- Grants one transaction at a time, latches data and chip-select for the whole transfer, and enforces a minimum request-low gap between transfers. The gap makes the derived DACx_CSn rise, which latches each word.
- Watchdogs each transfer and reports a hung SPI master via a sticky error flag.

---
 rtl/dac_spi_arb_if.sv | 32 +++
 rtl/dac_spi_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/dac_spi_arb_if.sv
// Bus bundle between the DAC SPI arbiter and its two requesters plus the SPI master.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface dac_spi_arb_if #(
  parameter int DATA_W = 24
);
  logic              req0;
  logic              sel0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic              sel1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              spi_wr_req;
  logic [DATA_W-1:0] spi_wr_data;
  logic              spi_sel;
  logic              spi_ack;
  logic              busy;
  logic              grant_id;
  logic              timeout_err;
  logic              err_clr;

  modport slave (
    input  req0, sel0, data0, req1, sel1, data1, spi_ack, err_clr,
    output ack0, ack1, spi_wr_req, spi_wr_data, spi_sel, busy, grant_id, timeout_err
  );

  modport master (
    output req0, sel0, data0, req1, sel1, data1, spi_ack, err_clr,
    input  ack0, ack1, spi_wr_req, spi_wr_data, spi_sel, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/dac_spi_arb.sv
// Two-port round-robin arbiter in front of the LTC2612 SPI master: one latched
// transfer at a time, a forced request-low gap so DACx_CSn rises, and a watchdog.
module dac_spi_arb #(
  parameter int DATA_W         = 24,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  dac_spi_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WDOG_END = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       GAP_END  = 8'(GAP_CYCLES - 1);

  state_t            r_state;
  logic              r_wr_req;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_sel;
  logic              r_grant_id;
  logic              r_last_grant;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_wdog;
  logic [7:0]        r_gap;

  logic w_any;
  logic w_pick1;
  logic w_wdog_hit;
  logic w_set_err;

  // Port 1 wins only when it is alone, or when both ask and port 0 went last.
  assign w_any      = bus.req0 | bus.req1;
  assign w_pick1    = bus.req1 & (~bus.req0 | ~r_last_grant);
  assign w_wdog_hit = WDOG_EN & (r_wdog == WDOG_END);
  assign w_set_err  = (r_state == ISSUE) & ~bus.spi_ack & w_wdog_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_wr_req      <= 1'b0;
      r_wr_data     <= '0;
      r_sel         <= 1'b0;
      r_grant_id    <= 1'b0;
      r_last_grant  <= 1'b1;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wdog        <= '0;
      r_gap         <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_set_err) begin
        r_timeout_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= ISSUE;
            r_wr_req     <= 1'b1;
            r_busy       <= 1'b1;
            r_grant_id   <= w_pick1;
            r_last_grant <= w_pick1;
            r_wr_data    <= w_pick1 ? bus.data1 : bus.data0;
            r_sel        <= w_pick1 ? bus.sel1 : bus.sel0;
            r_wdog       <= '0;
          end
        end
        ISSUE: begin
          // A real ack beats a watchdog expiry in the same cycle; both end the same way.
          if (bus.spi_ack || w_wdog_hit) begin
            r_state  <= GAP;
            r_wr_req <= 1'b0;
            r_gap    <= '0;
            r_ack0   <= ~r_grant_id;
            r_ack1   <= r_grant_id;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        GAP: begin
          if (r_gap == GAP_END) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.spi_wr_req  = r_wr_req;
  assign bus.spi_wr_data = r_wr_data;
  assign bus.spi_sel     = r_sel;
  assign bus.grant_id    = r_grant_id;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule
